// File: rtl/master_traffic_gen_if.sv
// Request/acknowledge master port bundle used by the traffic generator.
// The master drives req/addr/cmd/wdata; the slave answers with ack and,
// one cycle after a read ack, rdata.
interface master_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              cmd;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, cmd, wdata, input ack, rdata);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata);
endinterface

// File: rtl/master_traffic_gen.sv
// Traffic-generating bus master: issues a programmed number of read/write
// transactions in one of four address/command patterns, checks read data
// against a shadow copy of what it last wrote, and flags ack timeouts.
module master_traffic_gen #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          SLV_SEL_W = 1,
  parameter int          LOCAL_AW  = 5,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
  parameter int          TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 num_trans,
  input  logic [3:0]                  gap,
  master_traffic_gen_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 trans_cnt,
  output logic [15:0]                 err_mismatch_cnt,
  output logic                        err_timeout
);

  localparam int          PW    = SLV_SEL_W + LOCAL_AW;
  localparam int          DEPTH = 1 << PW;
  localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RDATA, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {M_WR_RD, M_RANDOM, M_SEQ_WRITE, M_SEQ_READ} mode_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
  endfunction

  state_t            state_q, state_d;
  mode_t             mode_q, m_cur;
  logic [31:0]       lfsr_q, l_cur;
  logic [PW-1:0]     ptr_q, p_cur;
  logic              pair_q, pair_cur;
  logic [PW-1:0]     pair_loc_q;
  logic [15:0]       num_q;
  logic [3:0]        gap_q, gap_cnt_q;
  logic [TW-1:0]     to_cnt_q;
  logic [PW-1:0]     loc_q, l_loc, rnd_loc;
  logic              cmd_q, l_cmd;
  logic [DATA_W-1:0] wdata_q, l_wdata;
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [ADDR_W-1:0] addr_full;

  logic start_ok, launch, complete, timeout_hit, wr_ack;

  assign wr_ack = (state_q == S_ISSUE) && bus.ack && cmd_q;

  // Next-state decode: start acceptance, ack/timeout handling, completion routing.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    start_ok    = 1'b0;
    launch      = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          if (num_trans == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            launch  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.ack) begin
          if (cmd_q) complete = 1'b1;
          else       state_d  = S_RDATA;
        end else if (TIMEOUT != 0 && to_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_RDATA: complete = 1'b1;
      S_GAP: begin
        if (gap_cnt_q == 4'd1) begin
          state_d = S_ISSUE;
          launch  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      if (trans_cnt + 16'd1 == num_q) begin
        state_d = S_DONE;
      end else if (gap_q == 4'd0) begin
        state_d = S_ISSUE;
        launch  = 1'b1;
      end else begin
        state_d = S_GAP;
      end
    end
  end

  // Launch decode: address/command/data for the transaction about to be issued.
  // On the start edge the run-level state is taken as freshly reset.
  always_comb begin
    l_cur    = start_ok ? LFSR_SEED : lfsr_q;
    p_cur    = start_ok ? '0 : ptr_q;
    pair_cur = start_ok ? 1'b0 : pair_q;
    m_cur    = start_ok ? mode_t'(mode) : mode_q;
    rnd_loc  = {l_cur[31 -: SLV_SEL_W], l_cur[LOCAL_AW:1]};
    l_loc    = rnd_loc;
    l_cmd    = l_cur[0];
    case (m_cur)
      M_WR_RD: begin
        l_cmd = ~pair_cur;
        l_loc = pair_cur ? pair_loc_q : rnd_loc;
      end
      M_SEQ_WRITE: begin
        l_cmd = 1'b1;
        l_loc = p_cur;
      end
      M_SEQ_READ: begin
        l_cmd = 1'b0;
        l_loc = p_cur;
      end
      default: ;
    endcase
    l_wdata = l_cmd ? DATA_W'({~l_cur, l_cur}) : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Run control, launch latching, counters and error flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q           <= M_WR_RD;
      lfsr_q           <= LFSR_SEED;
      ptr_q            <= '0;
      pair_q           <= 1'b0;
      pair_loc_q       <= '0;
      num_q            <= '0;
      gap_q            <= '0;
      gap_cnt_q        <= '0;
      to_cnt_q         <= '0;
      loc_q            <= '0;
      cmd_q            <= 1'b0;
      wdata_q          <= '0;
      trans_cnt        <= '0;
      err_mismatch_cnt <= '0;
      err_timeout      <= 1'b0;
      valid_q          <= '0;
    end else begin
      if (start_ok) begin
        lfsr_q           <= LFSR_SEED;
        ptr_q            <= '0;
        pair_q           <= 1'b0;
        trans_cnt        <= '0;
        err_mismatch_cnt <= '0;
        err_timeout      <= 1'b0;
        mode_q           <= mode_t'(mode);
        num_q            <= num_trans;
        gap_q            <= gap;
      end
      // NOTE: nonblocking updates let a launch on the start edge override the clears above.
      if (launch) begin
        loc_q    <= l_loc;
        cmd_q    <= l_cmd;
        wdata_q  <= l_wdata;
        lfsr_q   <= lfsr_step(l_cur);
        ptr_q    <= p_cur + PW'(1);
        to_cnt_q <= '0;
        if (m_cur == M_WR_RD) begin
          pair_q <= ~pair_cur;
          if (!pair_cur) pair_loc_q <= rnd_loc;
        end
      end else if (state_q == S_ISSUE && !bus.ack) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
      if (complete) trans_cnt <= trans_cnt + 16'd1;
      if (complete && state_d == S_GAP) gap_cnt_q <= gap_q;
      else if (state_q == S_GAP)        gap_cnt_q <= gap_cnt_q - 4'd1;
      if (state_q == S_RDATA && valid_q[loc_q] && bus.rdata != shadow[loc_q] &&
          err_mismatch_cnt != 16'hFFFF)
        err_mismatch_cnt <= err_mismatch_cnt + 16'd1;
      if (timeout_hit) err_timeout <= 1'b1;
      if (wr_ack) valid_q[loc_q] <= 1'b1;
    end
  end

  // Shadow data: only the valid bits are reset, stale data is never compared.
  // NOTE: the data array has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ack) shadow[loc_q] <= wdata_q;
  end

  // Spread the {sel,index} location over the full address; other bits stay 0.
  always_comb begin
    addr_full                              = '0;
    addr_full[ADDR_W-1 -: SLV_SEL_W]       = loc_q[PW-1 -: SLV_SEL_W];
    addr_full[LOCAL_AW-1:0]                = loc_q[LOCAL_AW-1:0];
  end

  assign bus.req   = (state_q == S_ISSUE);
  assign bus.addr  = addr_full;
  assign bus.cmd   = cmd_q;
  assign bus.wdata = wdata_q;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_RDATA) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_master_traffic_gen.sv
// Self-checking bench for master_traffic_gen: a bench-side reference model
// queues the expected transactions at each start; a slave model pops and
// compares them on every ack and returns read data from its own memory.
module tb_master_traffic_gen;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          TO   = 16;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_trans = 16'd0;
  logic [3:0]  gap = 4'd0;
  logic        busy, done, err_timeout;
  logic [15:0] trans_cnt, err_mismatch_cnt;

  master_traffic_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  master_traffic_gen #(
    .DATA_W(DW), .ADDR_W(AW), .SLV_SEL_W(1), .LOCAL_AW(5),
    .LFSR_SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .mode             (mode),
    .num_trans        (num_trans),
    .gap              (gap),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .trans_cnt        (trans_cnt),
    .err_mismatch_cnt (err_mismatch_cnt),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference model: the whole run's transaction list, in issue order.
  task automatic push_expected(input logic [1:0] m, input int n);
    logic [31:0] l = SEED;
    logic [5:0]  p = '0;
    logic [5:0]  pa = '0;
    logic [5:0]  loc;
    logic        c;
    bit          pair = 1'b0;
    txn_t        t;
    for (int i = 0; i < n; i++) begin
      loc = {l[31], l[5:1]};
      c   = l[0];
      case (m)
        2'd0: begin
          c = !pair;
          if (!pair) pa = loc; else loc = pa;
          pair = !pair;
        end
        2'd2: begin c = 1'b1; loc = p; end
        2'd3: begin c = 1'b0; loc = p; end
        default: ;
      endcase
      p++;
      t.addr  = {loc[5], 26'b0, loc[4:0]};
      t.cmd   = c;
      t.wdata = c ? l : 32'h0;
      exp_q.push_back(t);
      l = lfsr_nx(l);
    end
  endtask

  // Slave model controls.
  int          ack_dly = 0;
  bit          never_ack = 1'b0;
  int          corrupt_loc = -1;
  bit          garbage = 1'b0;
  logic [31:0] smem [64];

  initial begin
    int          wait_cnt;
    bit          rd_pend;
    logic [31:0] rd_val;
    int          loc;
    txn_t        e;
    wait_cnt = 0;
    rd_pend  = 1'b0;
    rd_val   = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    foreach (smem[i]) smem[i] = '0;
    forever begin
      @(negedge clk);
      bus.ack   = 1'b0;
      bus.rdata = rd_pend ? rd_val : $urandom;
      rd_pend   = 1'b0;
      if (bus.req && !never_ack) begin
        if (wait_cnt >= ack_dly) begin
          wait_cnt = 0;
          bus.ack  = 1'b1;
          loc = int'({bus.addr[31], bus.addr[4:0]});
          check("sb_nonempty", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("addr", bus.addr, e.addr);
            check("cmd", bus.cmd, e.cmd);
            check("wdata", bus.wdata, e.wdata);
          end
          if (bus.cmd) begin
            smem[loc] = bus.wdata;
          end else begin
            rd_pend = 1'b1;
            rd_val  = smem[loc];
            if (garbage)                 rd_val = ~rd_val;
            else if (loc == corrupt_loc) rd_val = rd_val ^ 32'h1;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Lengths of req-low stretches between transactions of a busy run.
  int low_runs[$];
  int low_run = 0;
  initial forever begin
    @(negedge clk);
    if (!busy) low_run = 0;
    else if (!bus.req) low_run++;
    else if (low_run > 0) begin
      low_runs.push_back(low_run);
      low_run = 0;
    end
  end

  task automatic start_run(input logic [1:0] m, input int n, input logic [3:0] g);
    exp_q.delete();
    push_expected(m, n);
    @(negedge clk);
    mode = m; num_trans = 16'(n); gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    int hi;
    int exp_runs[5] = '{3, 4, 3, 4, 3};

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", bus.req, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tcnt", trans_cnt, 0);
    check("rst_mis", err_mismatch_cnt, 0);
    check("rst_to", err_timeout, 0);
    resetn = 1'b1;

    // Zero-length run: done one cycle after start, no request.
    start_run(2'd1, 0, 4'd0);
    check("n0_done", done, 1);
    check("n0_req", bus.req, 0);
    check("n0_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("n0_req_later", bus.req, 0);

    // Sequential writes.
    ack_dly = 2;
    start_run(2'd2, 4, 4'd0);
    wait_done(200);
    check("sw_tcnt", trans_cnt, 4);
    check("sw_sb_left", exp_q.size(), 0);

    // Sequential reads of matching data, then with one corrupted location.
    start_run(2'd3, 4, 4'd0);
    wait_done(200);
    check("sr_tcnt", trans_cnt, 4);
    check("sr_mis", err_mismatch_cnt, 0);
    check("sr_sb_left", exp_q.size(), 0);
    corrupt_loc = 2;
    start_run(2'd3, 4, 4'd0);
    wait_done(200);
    check("src_mis", err_mismatch_cnt, 1);
    check("src_sb_left", exp_q.size(), 0);
    corrupt_loc = -1;

    // Write/read pairs with gaps; a start pulse mid-run must be ignored.
    ack_dly = 1;
    low_runs.delete();
    start_run(2'd0, 6, 4'd3);
    repeat (4) @(negedge clk);
    check("pulse_busy", busy, 1);
    mode = 2'd2; num_trans = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    check("wr_tcnt", trans_cnt, 6);
    check("wr_mis", err_mismatch_cnt, 0);
    check("wr_sb_left", exp_q.size(), 0);
    check("wr_gap_count", low_runs.size(), 5);
    for (int i = 0; i < 5 && i < low_runs.size(); i++)
      check($sformatf("wr_gap%0d", i), low_runs[i], exp_runs[i]);

    // Ack timeout.
    never_ack = 1'b1;
    start_run(2'd1, 5, 4'd0);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req) hi++;
      if (done) break;
      @(negedge clk);
    end
    check("to_req_cycles", hi, TO);
    check("to_flag", err_timeout, 1);
    check("to_done", done, 1);
    check("to_tcnt", trans_cnt, 0);
    check("to_req_low", bus.req, 0);
    never_ack = 1'b0;
    start_run(2'd1, 0, 4'd0);
    check("to_cleared", err_timeout, 0);
    check("to_n0_done", done, 1);

    // Reset in the middle of an issued request.
    never_ack = 1'b1;
    start_run(2'd2, 4, 4'd0);
    repeat (2) @(negedge clk);
    check("mid_req", bus.req, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst_req", bus.req, 0);
    check("mrst_addr", bus.addr, 0);
    check("mrst_cmd", bus.cmd, 0);
    check("mrst_wdata", bus.wdata, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_tcnt", trans_cnt, 0);
    resetn = 1'b1;
    never_ack = 1'b0;

    // Garbage read data after reset: shadow valid bits are clear.
    garbage = 1'b1;
    ack_dly = 0;
    start_run(2'd3, 4, 4'd0);
    wait_done(200);
    check("gr_tcnt", trans_cnt, 4);
    check("gr_mis", err_mismatch_cnt, 0);
    check("gr_sb_left", exp_q.size(), 0);
    garbage = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
